// File: rtl/ov9281_pkg.sv
// rtl/ov9281_pkg.sv - CSI-2 data types, packet header layout and receiver states
package ov9281_pkg;

    localparam logic [5:0] DT_FS        = 6'h00;
    localparam logic [5:0] DT_FE        = 6'h01;
    localparam logic [5:0] DT_LS        = 6'h02;
    localparam logic [5:0] DT_LE        = 6'h03;
    localparam logic [5:0] DT_RAW10     = 6'h2B;
    localparam logic [5:0] DT_SHORT_MAX = 6'h10;

    typedef struct packed {
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
    } csi2_hdr_t;

    typedef enum logic [2:0] {
        ST_DISARMED,
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_CRC,
        ST_SKIP
    } rx_state_t;

    // A RAW10 line must hold a whole number of 5-byte pixel groups.
    function automatic logic raw10_wc_legal(input logic [15:0] wc, input logic [15:0] max_wc);
        return (wc != 16'd0) && ((wc % 16'd5) == 16'd0) && (wc <= max_wc);
    endfunction

endpackage

// File: rtl/raw10_unpack.sv
// rtl/raw10_unpack.sv - assembles RAW10 5-byte groups into four 10-bit pixels with line tags
module raw10_unpack (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_valid,
    input  logic        i_last,
    input  logic [7:0]  i_byte,
    output logic [39:0] o_pix,
    output logic        o_pix_valid,
    output logic        o_sol,
    output logic        o_eol
);

    logic [31:0] r_sh;
    logic [2:0]  r_phase;
    logic        r_first;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh        <= '0;
            r_phase     <= '0;
            r_first     <= 1'b0;
            o_pix       <= '0;
            o_pix_valid <= 1'b0;
            o_sol       <= 1'b0;
            o_eol       <= 1'b0;
        end else begin
            o_pix_valid <= 1'b0;
            o_sol       <= 1'b0;
            o_eol       <= 1'b0;
            // A new header restarts the phase, which discards any truncated group.
            if (i_start) begin
                r_phase <= '0;
                r_first <= 1'b1;
            end else if (i_valid) begin
                if (r_phase == 3'd4) begin
                    o_pix       <= {r_sh[31:24], i_byte[7:6], r_sh[23:16], i_byte[5:4],
                                    r_sh[15:8],  i_byte[3:2], r_sh[7:0],   i_byte[1:0]};
                    o_pix_valid <= 1'b1;
                    o_sol       <= r_first;
                    o_eol       <= i_last;
                    r_first     <= 1'b0;
                    r_phase     <= '0;
                end else begin
                    r_sh    <= {i_byte, r_sh[31:8]};
                    r_phase <= r_phase + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/ov9281_csi2_rx_unpack.sv
// rtl/ov9281_csi2_rx_unpack.sv - CSI-2 packet parser with frame/line tracking and RAW10 unpack
module ov9281_csi2_rx_unpack #(
    parameter logic [1:0]  VC     = 2'd0,
    parameter logic [15:0] MAX_WC = 16'd1600,
    parameter int          LINE_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cfg_done,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_valid,
    input  logic              i_sot,
    output logic [39:0]       o_pix,
    output logic              o_pix_valid,
    output logic              o_sol,
    output logic              o_eol,
    output logic              o_sof,
    output logic              o_eof,
    output logic [LINE_W-1:0] o_line_cnt,
    output logic [15:0]       o_frame_cnt,
    output logic              o_err_len,
    output logic              o_err_trunc
);
    import ov9281_pkg::*;

    rx_state_t   r_state, w_state_nxt;
    logic [7:0]  r_di;
    logic [15:0] r_wc;
    logic [1:0]  r_hdr_idx;
    logic [16:0] r_rem;
    csi2_hdr_t   w_hdr;
    logic        w_sot, w_byte, w_in_pkt, w_hdr_done, w_is_short, w_vc_ok;
    logic        w_raw, w_raw_ok, w_rem_last, w_pay_byte, w_pay_last;

    assign w_hdr      = '{vc: r_di[7:6], dt: r_di[5:0], wc: r_wc};
    assign w_sot      = i_byte_valid & i_sot;
    assign w_byte     = i_byte_valid & ~i_sot;
    assign w_in_pkt   = r_state inside {ST_HDR, ST_PAYLOAD, ST_CRC, ST_SKIP};
    assign w_hdr_done = (r_state == ST_HDR) && w_byte && (r_hdr_idx == 2'd3);
    assign w_is_short = w_hdr.dt < DT_SHORT_MAX;
    assign w_vc_ok    = w_hdr.vc == VC;
    assign w_raw      = !w_is_short && (w_hdr.dt == DT_RAW10) && w_vc_ok;
    assign w_raw_ok   = w_raw && raw10_wc_legal(w_hdr.wc, MAX_WC);
    assign w_rem_last = r_rem == 17'd1;
    assign w_pay_byte = (r_state == ST_PAYLOAD) && w_byte;
    assign w_pay_last = w_pay_byte && w_rem_last;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_DISARMED: if (i_cfg_done) w_state_nxt = ST_IDLE;
            ST_IDLE:     if (w_sot) w_state_nxt = ST_HDR;
            ST_HDR: begin
                if (w_sot)
                    w_state_nxt = ST_HDR;
                else if (w_hdr_done)
                    w_state_nxt = w_is_short ? ST_IDLE : (w_raw_ok ? ST_PAYLOAD : ST_SKIP);
            end
            ST_PAYLOAD: begin
                if (w_sot)
                    w_state_nxt = ST_HDR;
                else if (w_byte && w_rem_last)
                    w_state_nxt = ST_CRC;
            end
            ST_CRC, ST_SKIP: begin
                if (w_sot)
                    w_state_nxt = ST_HDR;
                else if (w_byte && w_rem_last)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_DISARMED;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_DISARMED;
            r_di        <= '0;
            r_wc        <= '0;
            r_hdr_idx   <= '0;
            r_rem       <= '0;
            o_sof       <= 1'b0;
            o_eof       <= 1'b0;
            o_err_len   <= 1'b0;
            o_err_trunc <= 1'b0;
            o_line_cnt  <= '0;
            o_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            o_sof       <= 1'b0;
            o_eof       <= 1'b0;
            o_err_len   <= 1'b0;
            o_err_trunc <= w_sot && w_in_pkt;
            if (w_sot && (r_state != ST_DISARMED)) begin
                r_di      <= i_byte;
                r_hdr_idx <= 2'd1;
            end else if ((r_state == ST_HDR) && w_byte) begin
                r_hdr_idx <= r_hdr_idx + 2'd1;
                if (r_hdr_idx == 2'd1) r_wc[7:0]  <= i_byte;
                if (r_hdr_idx == 2'd2) r_wc[15:8] <= i_byte;
                if (w_hdr_done) begin
                    if (w_is_short) begin
                        if (w_vc_ok) begin
                            case (w_hdr.dt)
                                DT_FS: begin
                                    o_sof      <= 1'b1;
                                    o_line_cnt <= '0;
                                end
                                DT_FE: begin
                                    o_eof       <= 1'b1;
                                    o_frame_cnt <= o_frame_cnt + 16'd1;
                                end
                                DT_LS, DT_LE: ;
                                default: ;
                            endcase
                        end
                    end else if (w_raw_ok) begin
                        r_rem <= {1'b0, w_hdr.wc};
                    end else begin
                        // Skip covers the payload and its 2-byte CRC.
                        r_rem     <= {1'b0, w_hdr.wc} + 17'd2;
                        o_err_len <= w_raw;
                    end
                end
            end else if (w_byte && (r_state inside {ST_PAYLOAD, ST_CRC, ST_SKIP})) begin
                r_rem <= r_rem - 17'd1;
                if (w_pay_last) begin
                    r_rem <= 17'd2;
                    if (o_line_cnt != '1) o_line_cnt <= o_line_cnt + LINE_W'(1);
                end
            end
        end
    end

    raw10_unpack u_unpack (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (w_hdr_done && w_raw_ok),
        .i_valid     (w_pay_byte),
        .i_last      (w_pay_last),
        .i_byte      (i_byte),
        .o_pix       (o_pix),
        .o_pix_valid (o_pix_valid),
        .o_sol       (o_sol),
        .o_eol       (o_eol)
    );

endmodule

// File: tb/tb_ov9281_csi2_rx_unpack.sv
// tb/tb_ov9281_csi2_rx_unpack.sv - directed-vector bench for the CSI-2 RAW10 receiver
module tb_ov9281_csi2_rx_unpack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_done = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        byte_valid = 1'b0;
    logic        sot = 1'b0;
    logic [39:0] o_pix;
    logic        o_pix_valid, o_sol, o_eol, o_sof, o_eof, o_err_len, o_err_trunc;
    logic [11:0] o_line_cnt;
    logic [15:0] o_frame_cnt;

    ov9281_csi2_rx_unpack dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cfg_done   (cfg_done),
        .i_byte       (din),
        .i_byte_valid (byte_valid),
        .i_sot        (sot),
        .o_pix        (o_pix),
        .o_pix_valid  (o_pix_valid),
        .o_sol        (o_sol),
        .o_eol        (o_eol),
        .o_sof        (o_sof),
        .o_eof        (o_eof),
        .o_line_cnt   (o_line_cnt),
        .o_frame_cnt  (o_frame_cnt),
        .o_err_len    (o_err_len),
        .o_err_trunc  (o_err_trunc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int c_pix = 0, c_sol = 0, c_eol = 0, c_sof = 0, c_eof = 0, c_elen = 0, c_etr = 0;
    logic [39:0] last_pix = '0;
    logic        last_sol = 1'b0, last_eol = 1'b0;
    logic [7:0]  pay [0:1607];

    localparam logic [39:0] S2_PIX = 40'h01E02007FC;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_pix_valid) begin
                c_pix++;
                last_pix = o_pix;
                last_sol = o_sol;
                last_eol = o_eol;
            end
            if (o_sol)       c_sol++;
            if (o_eol)       c_eol++;
            if (o_sof)       c_sof++;
            if (o_eof)       c_eof++;
            if (o_err_len)   c_elen++;
            if (o_err_trunc) c_etr++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic s, input bit gap);
        if (gap) begin
            repeat ($urandom_range(0, 2)) begin
                din = 8'($urandom);
                tick();
            end
        end
        din        = b;
        byte_valid = 1'b1;
        sot        = s;
        tick();
        byte_valid = 1'b0;
        sot        = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] di, input logic [15:0] wc, input bit gap);
        send_byte(di, 1'b1, gap);
        send_byte(wc[7:0], 1'b0, gap);
        send_byte(wc[15:8], 1'b0, gap);
        send_byte(8'h5A, 1'b0, gap);
    endtask

    task automatic send_short(input logic [1:0] vc, input logic [5:0] dt, input bit gap);
        send_hdr({vc, dt}, 16'h0000, gap);
    endtask

    task automatic send_raw(input logic [1:0] vc, input logic [15:0] wc, input int nbytes, input bit gap);
        bit          emit_ok;
        logic [7:0]  g [5];
        logic [41:0] exp;
        emit_ok = (vc == 2'd0) && (wc != 16'd0) && ((wc % 16'd5) == 16'd0) && (wc <= 16'd1600);
        send_hdr({vc, 6'h2B}, wc, gap);
        for (int i = 0; i < nbytes; i++) begin
            send_byte(pay[i], 1'b0, gap);
            g[i % 5] = pay[i];
            if (emit_ok && (i % 5 == 4)) begin
                exp = {(i == 4), (i == int'(wc) - 1),
                       g[3], g[4][7:6], g[2], g[4][5:4], g[1], g[4][3:2], g[0], g[4][1:0]};
                chk("pix_valid", o_pix_valid, 1);
                chk("pix_group", {o_sol, o_eol, o_pix}, exp);
            end else begin
                chk("pix_idle", o_pix_valid, 0);
            end
        end
        if (nbytes == int'(wc)) begin
            send_byte(8'hC3, 1'b0, gap);
            send_byte(8'h3C, 1'b0, gap);
        end
    endtask

    task automatic load_s2();
        pay[0] = 8'hFF; pay[1] = 8'h00; pay[2] = 8'h80; pay[3] = 8'h01; pay[4] = 8'hE4;
    endtask

    int b_pix, b_sol, b_eol, b_sof, b_eof, b_elen, b_etr;

    task automatic snap();
        b_pix = c_pix; b_sol = c_sol; b_eol = c_eol; b_sof = c_sof;
        b_eof = c_eof; b_elen = c_elen; b_etr = c_etr;
    endtask

    task automatic arm();
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_pix", o_pix, 0);
        chk("rst_pulses", {o_pix_valid, o_sol, o_eol, o_sof, o_eof, o_err_len, o_err_trunc}, 0);
        chk("rst_line_cnt", o_line_cnt, 0);
        chk("rst_frame_cnt", o_frame_cnt, 0);
        rst = 1'b0;
        tick();

        // Disarmed receiver ignores FS until cfg_done.
        snap();
        send_short(2'd0, 6'h00, 1'b0);
        tick();
        chk("s1_no_sof", c_sof - b_sof, 0);
        arm();
        send_short(2'd0, 6'h00, 1'b0);
        chk("s1_sof_pulse", o_sof, 1);
        tick();
        chk("s1_sof_width", o_sof, 0);
        chk("s1_sof_count", c_sof - b_sof, 1);

        // Single WC=5 RAW10 line.
        chk("s2_line_before", o_line_cnt, 0);
        load_s2();
        snap();
        send_raw(2'd0, 16'd5, 5, 1'b0);
        tick();
        chk("s2_groups", c_pix - b_pix, 1);
        chk("s2_pix", last_pix, S2_PIX);
        chk("s2_sol_eol", {last_sol, last_eol}, 2'b11);
        chk("s2_line_after", o_line_cnt, 1);

        // Frame of 20 maximum-length lines.
        snap();
        send_short(2'd0, 6'h00, 1'b0);
        chk("s3_line_reset", o_line_cnt, 0);
        for (int ln = 0; ln < 20; ln++) begin
            for (int i = 0; i < 1600; i++) pay[i] = 8'(i * 7 + ln * 13);
            send_raw(2'd0, 16'd1600, 1600, 1'b0);
        end
        send_short(2'd0, 6'h01, 1'b0);
        tick();
        chk("s3_groups", c_pix - b_pix, 6400);
        chk("s3_sol", c_sol - b_sol, 20);
        chk("s3_eol", c_eol - b_eol, 20);
        chk("s3_line_cnt", o_line_cnt, 20);
        chk("s3_frame_cnt", o_frame_cnt, 1);

        // Illegal word counts are flagged and skipped.
        for (int i = 0; i < 1608; i++) pay[i] = 8'(i * 29 + 3);
        snap();
        send_hdr(8'h2B, 16'd7, 1'b0);
        chk("s4_err_len_pulse", o_err_len, 1);
        for (int i = 0; i < 9; i++) send_byte(pay[i], 1'b0, 1'b0);
        send_raw(2'd0, 16'd1605, 1605, 1'b0);
        send_raw(2'd0, 16'd0, 0, 1'b0);
        send_short(2'd0, 6'h00, 1'b0);
        tick();
        chk("s4_err_len_count", c_elen - b_elen, 3);
        chk("s4_no_pix", c_pix - b_pix, 0);
        chk("s4_sof_after", c_sof - b_sof, 1);
        chk("s4_line_cnt", o_line_cnt, 0);

        // Truncation by a new SOT mid-payload.
        snap();
        send_raw(2'd0, 16'd10, 3, 1'b0);
        send_short(2'd0, 6'h01, 1'b0);
        tick();
        chk("s5_trunc", c_etr - b_etr, 1);
        chk("s5_no_pix", c_pix - b_pix, 0);
        chk("s5_eof", c_eof - b_eof, 1);
        chk("s5_frame_cnt", o_frame_cnt, 2);
        chk("s5_no_eol", c_eol - b_eol, 0);

        // Wrong VC dropped; byte gaps on the right VC.
        load_s2();
        snap();
        send_raw(2'd1, 16'd5, 5, 1'b1);
        tick();
        chk("s6_vc1_no_pix", c_pix - b_pix, 0);
        chk("s6_vc1_line", o_line_cnt, 0);
        chk("s6_vc1_no_err", c_elen - b_elen, 0);
        send_raw(2'd0, 16'd5, 5, 1'b1);
        tick();
        chk("s6_groups", c_pix - b_pix, 1);
        chk("s6_pix", last_pix, S2_PIX);
        chk("s6_sol_eol", {last_sol, last_eol}, 2'b11);
        chk("s6_line_after", o_line_cnt, 1);

        // Reset mid-packet returns to the disarmed state.
        send_hdr(8'h2B, 16'd10, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        chk("r_frame_cnt", o_frame_cnt, 0);
        chk("r_line_cnt", o_line_cnt, 0);
        chk("r_pix_valid", o_pix_valid, 0);
        rst = 1'b0;
        tick();
        snap();
        send_short(2'd0, 6'h00, 1'b0);
        tick();
        chk("r_disarmed_sof", c_sof - b_sof, 0);
        arm();
        send_short(2'd0, 6'h01, 1'b0);
        tick();
        chk("r_rearmed_eof", c_eof - b_eof, 1);
        chk("r_rearmed_frame", o_frame_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
